// File: rtl/lsu32.sv
`default_nettype none
// ============================================================================
// Module  : lsu32
// Purpose : Load/store unit for the rv32i core. Accepts one load or store per
//           handshake, drives the data BRAM ports, extends load data and
//           reports misaligned, illegal or out-of-range accesses.
// Revision: 1.0 - initial release
// ============================================================================
module lsu32 #(
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [31:0]           resp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_w_addr,
    output logic [31:0]           mem_w_dat,
    output logic                  mem_w_enb,
    output logic [3:0]            mem_byte_enb,
    output logic [ADDR_WIDTH-1:0] mem_r_addr,
    output logic                  mem_r_enb,
    input  logic [31:0]           mem_r_dat
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Read latency is at most 3, so a 2-bit counter suffices.
    localparam logic [1:0] LAT = 2'(READ_LATENCY);

    state_t                state_q, state_d;
    logic [2:0]            f3_q, f3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            cnt_q, cnt_d;

    logic                  req_bad;
    logic [31:0]           ld_shift;
    logic [31:0]           ld_ext;
    logic [3:0]            st_be;
    logic [31:0]           st_dat;

    // Classify the incoming request: illegal funct3, misalignment, range.
    always_comb begin
        req_bad = 1'b0;
        if (req_we) begin
            if (req_funct3[2] || (req_funct3[1:0] == 2'b11)) req_bad = 1'b1;
        end else begin
            if ((req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110)) req_bad = 1'b1;
        end
        if ((req_funct3[1:0] == 2'b01) && req_addr[0]) req_bad = 1'b1;
        if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) req_bad = 1'b1;
        // Range check uses the full 32-bit address before any truncation.
        if ((req_addr >> ADDR_WIDTH) != 32'd0) req_bad = 1'b1;
    end

    // Align the read word to the addressed byte and extend to 32 bits.
    always_comb begin
        ld_shift = mem_r_dat >> {addr_q[1:0], 3'b000};
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_ext = {24'd0, ld_shift[7:0]};
            3'b101:  ld_ext = {16'd0, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    // Build the byte mask and lane-replicated store data.
    always_comb begin
        st_be  = 4'b1111;
        st_dat = wdata_q;
        case (f3_q[1:0])
            2'b00: begin
                st_be  = 4'b0001 << addr_q[1:0];
                st_dat = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                st_be  = 4'b0011 << addr_q[1:0];
                st_dat = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    // State and latched-request registers; reset aborts any access at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accept in IDLE, one WRITE cycle, counted READ, RESP.
    always_comb begin
        state_d = state_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    f3_d    = req_funct3;
                    addr_d  = req_addr[ADDR_WIDTH-1:0];
                    wdata_d = req_wdata;
                    err_d   = req_bad;
                    rdata_d = 32'd0;
                    cnt_d   = 2'd0;
                    if (req_bad)     state_d = S_RESP;
                    else if (req_we) state_d = S_WRITE;
                    else             state_d = S_READ;
                end
            end
            S_WRITE: state_d = S_RESP;
            S_READ: begin
                if (cnt_q == LAT) begin
                    rdata_d = ld_ext;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state only, so enables never overlap.
    always_comb begin
        mem_w_enb    = 1'b0;
        mem_byte_enb = 4'd0;
        mem_w_dat    = 32'd0;
        mem_r_enb    = 1'b0;
        resp_valid   = 1'b0;
        resp_err     = 1'b0;
        resp_rdata   = 32'd0;
        case (state_q)
            S_WRITE: begin
                mem_w_enb    = 1'b1;
                mem_byte_enb = st_be;
                mem_w_dat    = st_dat;
            end
            S_READ: mem_r_enb = 1'b1;
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = rdata_q;
            end
            default: ;
        endcase
    end

    assign mem_w_addr = addr_q;
    assign mem_r_addr = addr_q;
    assign req_ready  = (state_q == S_IDLE) && rst_n;

endmodule
`default_nettype wire

// File: tb/tb_lsu32.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu32
// Purpose : Self-checking bench for lsu32. Two instances (read latency 0 and
//           2) share one request bus; each has its own BRAM model. Expected
//           results come from a byte-addressed reference memory.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lsu32;
    localparam int AW = 12;
    localparam int NH = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;

    logic          rdy [2];
    logic          rv [2];
    logic          rerr [2];
    logic          wen [2];
    logic          ren [2];
    logic [31:0]   rdat [2];
    logic [31:0]   wdat [2];
    logic [31:0]   mrd [2];
    logic [3:0]    be [2];
    logic [AW-1:0] wa [2];
    logic [AW-1:0] ra [2];

    always #5 clk = ~clk;

    lsu32 #(.ADDR_WIDTH(AW), .READ_LATENCY(0)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(rv[0]), .resp_err(rerr[0]),
        .resp_rdata(rdat[0]), .mem_w_addr(wa[0]), .mem_w_dat(wdat[0]),
        .mem_w_enb(wen[0]), .mem_byte_enb(be[0]), .mem_r_addr(ra[0]),
        .mem_r_enb(ren[0]), .mem_r_dat(mrd[0]));

    lsu32 #(.ADDR_WIDTH(AW), .READ_LATENCY(2)) u2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(rv[1]), .resp_err(rerr[1]),
        .resp_rdata(rdat[1]), .mem_w_addr(wa[1]), .mem_w_dat(wdat[1]),
        .mem_w_enb(wen[1]), .mem_byte_enb(be[1]), .mem_r_addr(ra[1]),
        .mem_r_enb(ren[1]), .mem_r_dat(mrd[1]));

    // Reference memory, byte addressed
    logic [7:0]  refm [4096];
    logic        load_mem = 1'b1;
    logic [31:0] mem0 [1024];
    logic [31:0] mem1 [1024];
    logic [31:0] p1, p2;

    // BRAM models: preloaded from the reference image, then byte-masked writes
    always @(posedge clk) begin
        if (load_mem) begin
            for (int w = 0; w < 1024; w++)
                mem0[w] <= {refm[4*w+3], refm[4*w+2], refm[4*w+1], refm[4*w]};
        end else if (wen[0]) begin
            for (int b = 0; b < 4; b++)
                if (be[0][b]) mem0[wa[0][11:2]][8*b +: 8] <= wdat[0][8*b +: 8];
        end
    end
    always @(posedge clk) begin
        if (load_mem) begin
            for (int w = 0; w < 1024; w++)
                mem1[w] <= {refm[4*w+3], refm[4*w+2], refm[4*w+1], refm[4*w]};
        end else if (wen[1]) begin
            for (int b = 0; b < 4; b++)
                if (be[1][b]) mem1[wa[1][11:2]][8*b +: 8] <= wdat[1][8*b +: 8];
        end
    end
    assign mrd[0] = ren[0] ? mem0[ra[0][11:2]] : 32'h5A5A5A5A;
    always @(posedge clk) begin
        p1 <= ren[1] ? mem1[ra[1][11:2]] : 32'h5A5A5A5A;
        p2 <= p1;
    end
    assign mrd[1] = p2;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s u%0d: got %h want %h", nm, inst, act, exp);
        end
    endtask

    // Per-cycle history after acceptance
    logic        h_w [2][NH];
    logic        h_r [2][NH];
    logic        h_v [2][NH];
    logic        h_e [2][NH];
    logic        h_rdy [2][NH];
    logic [31:0] h_rd [2][NH];
    logic [31:0] h_wd [2][NH];
    logic [3:0]  h_be [2][NH];
    logic [11:0] h_wa [2][NH];
    logic [11:0] h_ra [2][NH];
    int          rc_seen [2];

    task automatic sample(input int c);
        for (int i = 0; i < 2; i++) begin
            h_w[i][c] = wen[i];  h_r[i][c] = ren[i];  h_v[i][c] = rv[i];
            h_e[i][c] = rerr[i]; h_rdy[i][c] = rdy[i]; h_rd[i][c] = rdat[i];
            h_wd[i][c] = wdat[i]; h_be[i][c] = be[i]; h_wa[i][c] = wa[i];
            h_ra[i][c] = ra[i];
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'd0: return 1;
            2'd1: return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit is_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        if (we) legal = (f3 <= 3'd2);
        else    legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        if (!legal) return 1'b1;
        if ((a % size_of(f3)) != 0) return 1'b1;
        if (a >= 32'd4096) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ld_val(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        int n;
        n = size_of(f3);
        v = 32'd0;
        for (int k = 0; k < n; k++) v = v | (32'(refm[a + k]) << (8 * k));
        if (!f3[2] && (n < 4) && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
        return v;
    endfunction

    task automatic wait_ready();
        int k;
        k = 0;
        @(negedge clk);
        while (!(rdy[0] && rdy[1]) && (k < 20)) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) chk("ready timeout", 0, 32'd0, 32'd1);
    endtask

    task automatic eval_txn(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        bit          e;
        int          n, L, exp_rc, fv, nv, nw, nr, fr, ov, rachg;
        logic [31:0] exp_rd, exp_wd;
        logic [3:0]  exp_be;
        e = is_err(we, f3, a);
        n = size_of(f3);
        exp_rd = (e || we) ? 32'd0 : ld_val(f3, a);
        for (int l = 0; l < 4; l++) begin
            exp_wd[8*l +: 8] = wd[8*(l % n) +: 8];
            exp_be[l] = (l >= int'(a % 4)) && (l < int'(a % 4) + n);
        end
        for (int i = 0; i < 2; i++) begin
            L = (i == 0) ? 0 : 2;
            exp_rc = e ? 1 : (we ? 2 : 2 + L);
            fv = -1; nv = 0; nw = 0; nr = 0; fr = -1; ov = 0; rachg = 0;
            for (int c = 1; c < NH; c++) begin
                if (h_v[i][c]) begin nv++; if (fv < 0) fv = c; end
                if (h_w[i][c]) nw++;
                if (h_r[i][c]) begin
                    nr++;
                    if (h_ra[i][c] != a[11:0]) rachg++;
                end
                if (h_rdy[i][c] && (fr < 0)) fr = c;
                if (h_w[i][c] && h_r[i][c]) ov++;
            end
            rc_seen[i] = fv;
            chk("resp cycle", i, fv, exp_rc);
            chk("resp count", i, nv, 1);
            chk("wen cycles", i, nw, (!e && we) ? 1 : 0);
            chk("ren cycles", i, nr, (!e && !we) ? 1 + L : 0);
            chk("ready cycle", i, fr, exp_rc + 1);
            chk("en overlap", i, ov, 0);
            if (fv > 0) begin
                chk("resp err", i, {31'd0, h_e[i][fv]}, {31'd0, e});
                chk("resp rdata", i, h_rd[i][fv], exp_rd);
            end
            if (!e && we) begin
                chk("byte enb", i, {28'd0, h_be[i][1]}, {28'd0, exp_be});
                chk("w data", i, h_wd[i][1], exp_wd);
                chk("w addr", i, {20'd0, h_wa[i][1]}, {20'd0, a[11:0]});
            end
            if (!e && !we) chk("r addr held", i, rachg, 0);
        end
        if (!e && we)
            for (int k = 0; k < n; k++) refm[a + k] = wd[8*k +: 8];
    endtask

    task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        wait_ready();
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        for (int c = 1; c < NH; c++) begin
            @(negedge clk);
            sample(c);
        end
        eval_txn(we, f3, a, wd);
    endtask

    task automatic b2b();
        logic [31:0] wd;
        int L, nw, nr, fr, nv, ov;
        wd = $urandom;
        wait_ready();
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_we = 1'b0; req_wdata = $urandom;
        for (int c = 1; c < NH; c++) begin
            @(negedge clk);
            sample(c);
            if (c == 3) begin
                @(posedge clk);
                #1;
                req_valid = 1'b0;
            end
        end
        for (int i = 0; i < 2; i++) begin
            L = (i == 0) ? 0 : 2;
            nw = 0; nr = 0; fr = -1; nv = 0; ov = 0;
            for (int c = 1; c < NH; c++) begin
                if (h_w[i][c]) nw++;
                if (h_r[i][c]) begin nr++; if (fr < 0) fr = c; end
                if (h_v[i][c]) nv++;
                if (h_w[i][c] && h_r[i][c]) ov++;
            end
            chk("b2b wen cycles", i, nw, 1);
            chk("b2b busy ready", i, {31'd0, h_rdy[i][1] | h_rdy[i][2]}, 32'd0);
            chk("b2b ready c3", i, {31'd0, h_rdy[i][3]}, 32'd1);
            chk("b2b first ren", i, fr, 4);
            chk("b2b ren cycles", i, nr, 1 + L);
            chk("b2b resp count", i, nv, 2);
            chk("b2b load resp", i, {31'd0, h_v[i][5+L]}, 32'd1);
            chk("b2b load data", i, h_rd[i][5+L], wd);
            chk("b2b overlap", i, ov, 0);
        end
        for (int k = 0; k < 4; k++) refm[32'h40 + k] = wd[8*k +: 8];
    endtask

    task automatic reset_mid_read();
        int nv;
        wait_ready();
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst pre ren", 1, {31'd0, ren[1]}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst ren drop", i, {31'd0, ren[i]}, 32'd0);
            chk("rst no resp", i, {31'd0, rv[i]}, 32'd0);
            chk("rst ready low", i, {31'd0, rdy[i]}, 32'd0);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) chk("rst ready after", i, {31'd0, rdy[i]}, 32'd1);
        nv = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rv[0] || rv[1] || ren[0] || ren[1]) nv++;
        end
        chk("rst aborted quiet", 0, nv, 0);
    endtask

    typedef struct {
        bit          we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          cc;
        logic        cerr;
        logic [31:0] crd;
    } vec_t;

    vec_t tbl [15];

    initial begin
        bit          we;
        logic [2:0]  f3;
        logic [31:0] a;
        int          mm;
        tbl[0]  = '{1'b1, 3'b000, 32'h103,  32'hAABBCCDD, 1'b1, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 3'b000, 32'h11,   32'h0,        1'b1, 1'b0, 32'hFFFFFFBE};
        tbl[3]  = '{1'b0, 3'b100, 32'h11,   32'h0,        1'b1, 1'b0, 32'h000000BE};
        tbl[4]  = '{1'b0, 3'b001, 32'h12,   32'h0,        1'b1, 1'b0, 32'hFFFFDEAD};
        tbl[5]  = '{1'b0, 3'b010, 32'h10,   32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
        tbl[6]  = '{1'b0, 3'b001, 32'h1,    32'h0,        1'b1, 1'b1, 32'h0};
        tbl[7]  = '{1'b1, 3'b010, 32'h2,    32'h11223344, 1'b1, 1'b1, 32'h0};
        tbl[8]  = '{1'b0, 3'b011, 32'h20,   32'h0,        1'b1, 1'b1, 32'h0};
        tbl[9]  = '{1'b0, 3'b010, 32'h1000, 32'h0,        1'b1, 1'b1, 32'h0};
        tbl[10] = '{1'b1, 3'b001, 32'h22,   32'h12345678, 1'b1, 1'b0, 32'h0};
        tbl[11] = '{1'b0, 3'b101, 32'h22,   32'h0,        1'b1, 1'b0, 32'h00005678};
        tbl[12] = '{1'b0, 3'b010, 32'h20,   32'h0,        1'b0, 1'b0, 32'h0};
        tbl[13] = '{1'b1, 3'b100, 32'h30,   32'h55667788, 1'b1, 1'b1, 32'h0};
        tbl[14] = '{1'b0, 3'b010, 32'h10,   32'h0,        1'b1, 1'b0, 32'hDEADBEEF};

        for (int b = 0; b < 4096; b++) refm[b] = 8'($urandom);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset ctl", i, {24'd0, rdy[i], rv[i], rerr[i], wen[i], ren[i], 3'd0} | {28'd0, be[i]}, 32'd0);
            chk("reset rdata", i, rdat[i], 32'd0);
        end
        load_mem = 1'b0;
        rst_n = 1'b1;

        for (int t = 0; t < 15; t++) begin
            run_txn(tbl[t].we, tbl[t].f3, tbl[t].addr, tbl[t].wd);
            for (int i = 0; i < 2; i++) begin
                if (tbl[t].cc && (rc_seen[i] > 0)) begin
                    chk("tbl err", i, {31'd0, h_e[i][rc_seen[i]]}, {31'd0, tbl[t].cerr});
                    chk("tbl rdata", i, h_rd[i][rc_seen[i]], tbl[t].crd);
                end
            end
        end

        b2b();
        reset_mid_read();

        for (int t = 0; t < 60; t++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'h100 + $urandom_range(0, 63);
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(size_of(f3)) - 32'd1);
            if ($urandom_range(0, 9) == 0) a = $urandom;
            run_txn(we, f3, a, $urandom);
        end

        @(negedge clk);
        mm = 0;
        for (int w = 0; w < 1024; w++)
            if (mem0[w] !== {refm[4*w+3], refm[4*w+2], refm[4*w+1], refm[4*w]}) mm++;
        chk("mem image", 0, mm, 0);
        mm = 0;
        for (int w = 0; w < 1024; w++)
            if (mem1[w] !== {refm[4*w+3], refm[4*w+2], refm[4*w+1], refm[4*w]}) mm++;
        chk("mem image", 1, mm, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu32.md
# lsu32

Load/store unit for the rv32i core: the initiator that drives the 32-bit data BRAM's write, read and byte-enable ports on behalf of the execute stage. It accepts one load or store per handshake and decodes funct3 into byte enables and replicated write data. It applies sign or zero extension to load data and flags misaligned, illegal or out-of-range accesses. It sits between the core's memory stage and the data BRAM, and never asserts BRAM read and write enables together.

## Interface
- ADDR_WIDTH, 12: BRAM byte-address width; equals `RAM_ADDR_WIDTH`.
- READ_LATENCY, 0: cycles from mem_r_enb high to mem_r_dat valid; legal values 0..3.
- clk  in  1  core clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  access request.
- req_ready  out  1  unit can accept; equals (state==IDLE) && rst_n.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I load/store funct3.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (rs2).
- resp_valid  out  1  one-cycle pulse when the access completes.
- resp_err  out  1  qualifies resp_valid: misaligned, illegal funct3 or out of range.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- mem_w_addr  out  ADDR_WIDTH  BRAM write byte address.
- mem_w_dat  out  32  BRAM write data, lane-replicated.
- mem_w_enb  out  1  BRAM write enable.
- mem_byte_enb  out  4  BRAM byte mask.
- mem_r_addr  out  ADDR_WIDTH  BRAM read byte address.
- mem_r_enb  out  1  BRAM read enable.
- mem_r_dat  in  32  BRAM read word.

## Operation
- FSM states: IDLE, WRITE, READ, RESP. Reset state: IDLE.
- IDLE, on req_valid: latch req_* and classify the request.
  - Error if funct3 is illegal: loads accept 000/001/010/100/101 only; stores accept 000/001/010 only.
  - Error if misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - Error if req_addr[31:ADDR_WIDTH]≠0.
  - Error → RESP with resp_err=1; no BRAM enable is asserted.
  - Otherwise, a store goes to WRITE and a load goes to READ.
- WRITE, one cycle: mem_w_enb=1, mem_r_enb=0, mem_w_addr=latched addr[ADDR_WIDTH-1:0].
  - SB: mem_byte_enb=4'b0001<<addr[1:0], mem_w_dat={4{wdata[7:0]}}.
  - SH: mem_byte_enb=4'b0011<<addr[1:0], mem_w_dat={2{wdata[15:0]}}.
  - SW: mem_byte_enb=4'b1111, mem_w_dat=wdata.
  - Next state: RESP.
- READ: mem_r_enb=1 and mem_w_enb=0, with mem_r_addr held constant throughout.
  - A latency counter counts 0..READ_LATENCY.
  - mem_r_dat is captured when the counter equals READ_LATENCY; next state is RESP.
- Load extraction: sh = 8*addr[1:0]; w = mem_r_dat>>sh.
  - LB: sext(w[7:0]). LBU: zext(w[7:0]).
  - LH: sext(w[15:0]). LHU: zext(w[15:0]). LW: w.
- RESP, one cycle: resp_valid=1 with resp_err and resp_rdata valid, then IDLE.
- Outside WRITE: mem_w_enb=0 and mem_byte_enb=0. Outside READ: mem_r_enb=0.
- Outside RESP: resp_valid=0, resp_err=0, resp_rdata=0.

## Timing
- Reset values: every registered output is 0, and req_ready=0 while rst_n is low.
- Asserting rst_n mid-operation aborts the access immediately and asynchronously.
  - Enables drop in the same cycle and no resp_valid is issued.
  - req_ready=1 in the first cycle after release.
- Request accepted at edge T (req_valid && req_ready).
  - Store: mem_w_enb high in cycle T+1, resp_valid in T+2.
  - Load: mem_r_enb high in cycles T+1..T+1+READ_LATENCY, resp_valid in T+2+READ_LATENCY.
  - Error: resp_valid/resp_err in T+1.
- req_ready=0 from T+1 until the cycle after resp_valid; minimum issue interval is 3 cycles for a store.
- req_* are sampled only at acceptance; later changes are ignored.
- mem_w_enb and mem_r_enb are never high in the same cycle, including across state transitions.
- Width rules: mem addresses are truncated to ADDR_WIDTH only after the range check; extension is always to 32 bits.

## Test plan
- Reset: rst_n=0 mid-READ → mem_r_enb falls the same cycle; no resp_valid; req_ready=1 in the cycle after release.
- SB 0x0000_0103 with wdata=0xAABBCCDD → mem_byte_enb=4'b1000, mem_w_dat=0xDDDDDDDD, resp_valid at T+2 with resp_err=0.
- SW 0x10 with 0xDEADBEEF, then LB 0x11 → resp_rdata=0xFFFFFFBE. LBU 0x11 → 0x000000BE. LH 0x12 → 0xFFFFDEAD. LW 0x10 → 0xDEADBEEF.
- READ_LATENCY=2: LW → mem_r_enb high for exactly 3 cycles, resp_valid at T+4, value correct.
- LH 0x0001, SW 0x0002, funct3=3'b011, and LW 0x0000_1000 (ADDR_WIDTH=12) → each gives resp_err=1 at T+1; enables stay 0; memory is unchanged.
- Back-to-back: req_valid held high with a store then a load → the second request is accepted only after RESP; mem_w_enb and mem_r_enb never overlap.
